// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage (EX/MEM register, data RAM handshake, MEM-to-WB and forwarding buses)
//
// Optional feature macro: MEM_STAGE_BYPASS_EN
//   defined     : MEM_to_BY_bus carries forwarding information
//   not defined : MEM_to_BY_bus is tied to zero
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   EX_to_MEM_valid/bus upstream instruction and payload
//   MEM_allow_in        stage can accept an instruction this cycle
//   MEM_to_WB_valid/bus completed instruction toward write-back
//   WB_allow_in         write-back accepts this cycle
//   MEM_to_BY_bus       {fwd_we, fwd_load_pending, fwd_addr, fwd_data}
//   dram_req/we/addr/wstrb/wdata  data RAM request, held until dram_ack
//   dram_ack            request accepted
//   dram_rvalid/rdata   load response, honoured only while waiting for one

module mem_stage #(
    parameter int EX_BUS_WD = 110,
    parameter int WB_BUS_WD = 108,
    parameter int BY_BUS_WD = 39
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 EX_to_MEM_valid,
    input  logic [EX_BUS_WD-1:0] EX_to_MEM_bus,
    output logic                 MEM_allow_in,
    output logic                 MEM_to_WB_valid,
    output logic [WB_BUS_WD-1:0] MEM_to_WB_bus,
    input  logic                 WB_allow_in,
    output logic [BY_BUS_WD-1:0] MEM_to_BY_bus,
    output logic                 dram_req,
    output logic                 dram_we,
    output logic [31:0]          dram_addr,
    output logic [3:0]           dram_wstrb,
    output logic [31:0]          dram_wdata,
    input  logic                 dram_ack,
    input  logic                 dram_rvalid,
    input  logic [31:0]          dram_rdata
);

    // EX-to-MEM field positions
    localparam int EX_RF_WE   = 109;
    localparam int EX_IS_LOAD = 108;
    localparam int EX_IS_BYTE = 107;
    localparam int EX_MEM_EN  = 106;
    localparam int EX_MEM_WE  = 105;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        READY = 2'd3
    } state_t;

    state_t               state;
    logic [EX_BUS_WD-1:0] ex_reg;
    logic [31:0]          rdata_reg;

    logic        r_rf_we;
    logic        r_is_load;
    logic        r_is_byte;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [3:0]  r_b_en;
    logic [31:0] r_st_data;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_alu_result;
    logic [31:0] r_pc;

    assign r_rf_we      = ex_reg[EX_RF_WE];
    assign r_is_load    = ex_reg[EX_IS_LOAD];
    assign r_is_byte    = ex_reg[EX_IS_BYTE];
    assign r_mem_en     = ex_reg[EX_MEM_EN];
    assign r_mem_we     = ex_reg[EX_MEM_WE];
    assign r_b_en       = ex_reg[104:101];
    assign r_st_data    = ex_reg[100:69];
    assign r_rf_waddr   = ex_reg[68:64];
    assign r_alu_result = ex_reg[63:32];
    assign r_pc         = ex_reg[31:0];

    logic accept;

    // READY hands over to write-back and refills in the same cycle, so a
    // back-to-back instruction sees no bubble.
    assign MEM_allow_in = (state == EMPTY) || ((state == READY) && WB_allow_in);
    assign accept       = EX_to_MEM_valid && MEM_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            ex_reg    <= '0;
            rdata_reg <= '0;
        end else if (accept) begin
            ex_reg    <= EX_to_MEM_bus;
            // Cleared so non-loads carry rdata=0 downstream.
            rdata_reg <= '0;
            state     <= EX_to_MEM_bus[EX_MEM_EN] ? REQ : READY;
        end else begin
            case (state)
                REQ: begin
                    if (dram_ack) begin
                        state <= r_mem_we ? READY : WAIT;
                    end
                end
                WAIT: begin
                    // Responses seen in any other state (e.g. left over from
                    // a request dropped by reset) never reach this branch.
                    if (dram_rvalid) begin
                        rdata_reg <= dram_rdata;
                        state     <= READY;
                    end
                end
                READY: begin
                    if (WB_allow_in) begin
                        state <= EMPTY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM request: driven straight from the EX/MEM register, so it stays
    // stable for as long as the FSM sits in REQ.
    assign dram_req   = (state == REQ) && r_mem_en;
    assign dram_we    = r_mem_we;
    assign dram_addr  = r_alu_result;
    assign dram_wstrb = r_mem_we ? (r_is_byte ? r_b_en : 4'b1111) : 4'b0000;
    assign dram_wdata = r_is_byte ? {4{r_st_data[7:0]}} : r_st_data;

    assign MEM_to_WB_valid = (state == READY);
    assign MEM_to_WB_bus   = {r_rf_we, r_is_load, r_is_byte, r_b_en, rdata_reg,
                              r_rf_waddr, r_alu_result, r_pc};

`ifdef MEM_STAGE_BYPASS_EN
    logic        fwd_we;
    logic        fwd_load_pending;
    logic [31:0] fwd_data;

    assign fwd_we           = (state != EMPTY) && r_rf_we && (r_rf_waddr != 5'd0);
    // A load's value is unusable by the bypass unit until it has returned.
    assign fwd_load_pending = fwd_we && r_is_load && (state != READY);
    assign fwd_data         = r_is_load ? rdata_reg : r_alu_result;
    assign MEM_to_BY_bus    = {fwd_we, fwd_load_pending, r_rf_waddr, fwd_data};
`else
    assign MEM_to_BY_bus    = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a transaction-level model

module tb_mem_stage;

    localparam int EXW = 110;
    localparam int WBW = 108;
    localparam int BYW = 39;

    typedef struct packed {
        logic        rf_we;
        logic        is_load;
        logic        is_byte;
        logic        mem_en;
        logic        mem_we;
        logic [3:0]  b_en;
        logic [31:0] st_data;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [31:0] pc;
    } instr_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           ex_valid;
    logic [EXW-1:0] ex_bus;
    logic           mem_allow;
    logic           wb_valid;
    logic [WBW-1:0] wb_bus;
    logic           wb_allow;
    logic [BYW-1:0] by_bus;
    logic           dram_req;
    logic           dram_we;
    logic [31:0]    dram_addr;
    logic [3:0]     dram_wstrb;
    logic [31:0]    dram_wdata;
    logic           dram_ack;
    logic           dram_rvalid;
    logic [31:0]    dram_rdata;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .EX_to_MEM_valid (ex_valid),
        .EX_to_MEM_bus   (ex_bus),
        .MEM_allow_in    (mem_allow),
        .MEM_to_WB_valid (wb_valid),
        .MEM_to_WB_bus   (wb_bus),
        .WB_allow_in     (wb_allow),
        .MEM_to_BY_bus   (by_bus),
        .dram_req        (dram_req),
        .dram_we         (dram_we),
        .dram_addr       (dram_addr),
        .dram_wstrb      (dram_wstrb),
        .dram_wdata      (dram_wdata),
        .dram_ack        (dram_ack),
        .dram_rvalid     (dram_rvalid),
        .dram_rdata      (dram_rdata)
    );

    // Model: the held instruction plus what it still owes (a request, data).
    instr_t      m_i;
    logic        m_full;
    logic        m_need_ack;
    logic        m_need_data;
    logic [31:0] m_rdata;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic m_done();
        return m_full && !m_need_ack && !m_need_data;
    endfunction

    function automatic logic [WBW-1:0] exp_wb();
        return {m_i.rf_we, m_i.is_load, m_i.is_byte, m_i.b_en, m_rdata,
                m_i.waddr, m_i.alu, m_i.pc};
    endfunction

    function automatic logic [BYW-1:0] exp_by();
`ifdef MEM_STAGE_BYPASS_EN
        logic we;
        logic lp;
        we = m_full && m_i.rf_we && (m_i.waddr != 5'd0);
        lp = we && m_i.is_load && !m_done();
        return {we, lp, m_i.waddr, m_i.is_load ? m_rdata : m_i.alu};
`else
        return '0;
`endif
    endfunction

    // Advance the model across one clock edge using the inputs present before it.
    task automatic model_update();
        logic can_take;
        if (reset) begin
            m_i         = '0;
            m_full      = 1'b0;
            m_need_ack  = 1'b0;
            m_need_data = 1'b0;
            m_rdata     = '0;
        end else begin
            can_take = !m_full || (m_done() && wb_allow);
            if (m_full && m_need_ack) begin
                if (dram_ack) begin
                    m_need_ack  = 1'b0;
                    m_need_data = !m_i.mem_we;
                end
            end else if (m_full && m_need_data) begin
                if (dram_rvalid) begin
                    m_rdata     = dram_rdata;
                    m_need_data = 1'b0;
                end
            end else if (m_full && wb_allow) begin
                m_full = 1'b0;
            end
            if (ex_valid && can_take) begin
                m_i         = ex_bus;
                m_full      = 1'b1;
                m_rdata     = '0;
                m_need_ack  = m_i.mem_en;
                m_need_data = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("allow_in", mem_allow, !m_full || (m_done() && wb_allow));
            chk("wb_valid", wb_valid, m_done());
            chk("dram_req", dram_req, m_full && m_need_ack);
            if (m_done()) chk("wb_bus", wb_bus, exp_wb());
            if (m_full && m_need_ack) begin
                chk("dram_addr", dram_addr, m_i.alu);
                chk("dram_we", dram_we, m_i.mem_we);
                chk("dram_wstrb", dram_wstrb,
                    m_i.mem_we ? (m_i.is_byte ? m_i.b_en : 4'hF) : 4'h0);
                chk("dram_wdata", dram_wdata,
                    m_i.is_byte ? {4{m_i.st_data[7:0]}} : m_i.st_data);
            end
            chk("by_bus", by_bus, exp_by());
        end
    end

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        t         = '0;
        kind      = int'($urandom % 3);
        t.pc      = $urandom;
        t.alu     = $urandom;
        t.st_data = $urandom;
        t.waddr   = 5'($urandom % 32);
        t.b_en    = 4'hF;
        if (kind == 0) begin
            t.rf_we = (($urandom % 4) != 0);
        end else begin
            t.mem_en  = 1'b1;
            t.is_byte = (($urandom % 2) == 1);
            if (t.is_byte) t.b_en = 4'(1 << ($urandom % 4));
            if (kind == 1) begin
                t.is_load = 1'b1;
                t.rf_we   = 1'b1;
            end else begin
                t.mem_we  = 1'b1;
            end
        end
        return t;
    endfunction

    initial begin
        instr_t t;
        reset       = 1'b1;
        ex_valid    = 1'b0;
        ex_bus      = '0;
        wb_allow    = 1'b1;
        dram_ack    = 1'b0;
        dram_rvalid = 1'b0;
        dram_rdata  = '0;
        cyc();
        cyc();
        reset    = 1'b0;
        check_en = 1'b1;
        #2;
        chk("rst_allow", mem_allow, 1'b1);
        chk("rst_valid", wb_valid, 1'b0);
        chk("rst_req", dram_req, 1'b0);
        chk("rst_by", by_bus, '0);

        // ALU op
        t = '0; t.rf_we = 1'b1; t.waddr = 5'd5; t.alu = 32'h1234; t.pc = 32'h40; t.b_en = 4'hF;
        ex_valid = 1'b1; ex_bus = t;
        cyc();
        ex_valid = 1'b0;
        #2;
        chk("alu_valid", wb_valid, 1'b1);
        chk("alu_result", wb_bus[63:32], 32'h1234);
`ifdef MEM_STAGE_BYPASS_EN
        chk("alu_fwd_we", by_bus[38], 1'b1);
        chk("alu_fwd_data", by_bus[31:0], 32'h1234);
`else
        chk("alu_by_zero", by_bus, '0);
`endif
        cyc();

        // Byte store, ack in third request cycle
        t = '0; t.mem_en = 1'b1; t.mem_we = 1'b1; t.is_byte = 1'b1; t.b_en = 4'b0100;
        t.st_data = 32'hAB; t.alu = 32'h200; t.pc = 32'h44;
        ex_valid = 1'b1; ex_bus = t;
        cyc();
        ex_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dram_ack = (k == 2);
            #2;
            chk("st_req", dram_req, 1'b1);
            chk("st_wdata", dram_wdata, 32'hABABABAB);
            chk("st_wstrb", dram_wstrb, 4'b0100);
            chk("st_not_valid", wb_valid, 1'b0);
            cyc();
        end
        dram_ack = 1'b0;
        #2;
        chk("st_valid", wb_valid, 1'b1);
        cyc();

        // Load at 0x100, then a 4-cycle WB stall
        t = '0; t.rf_we = 1'b1; t.is_load = 1'b1; t.mem_en = 1'b1; t.waddr = 5'd7;
        t.alu = 32'h100; t.pc = 32'h48; t.b_en = 4'hF;
        ex_valid = 1'b1; ex_bus = t;
        cyc();
        ex_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dram_ack = (k == 3);
            #2;
            chk("ld_req", dram_req, 1'b1);
            chk("ld_addr", dram_addr, 32'h100);
            chk("ld_wstrb", dram_wstrb, 4'h0);
`ifdef MEM_STAGE_BYPASS_EN
            chk("ld_pending", by_bus[37], 1'b1);
`endif
            cyc();
        end
        dram_ack    = 1'b0;
        dram_rvalid = 1'b1;
        dram_rdata  = 32'hDEADBEEF;
        wb_allow    = 1'b0;
        #2;
        chk("ld_wait_valid", wb_valid, 1'b0);
        chk("ld_wait_req", dram_req, 1'b0);
        cyc();
        dram_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("stall_valid", wb_valid, 1'b1);
            chk("stall_allow", mem_allow, 1'b0);
            chk("stall_bus", wb_bus, {1'b1, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 5'd7, 32'h100, 32'h48});
`ifdef MEM_STAGE_BYPASS_EN
            chk("ld_ready_fwd", by_bus, {1'b1, 1'b0, 5'd7, 32'hDEADBEEF});
`endif
            cyc();
        end
        t = '0; t.rf_we = 1'b1; t.waddr = 5'd3; t.alu = 32'h55; t.pc = 32'h4C; t.b_en = 4'hF;
        wb_allow = 1'b1; ex_valid = 1'b1; ex_bus = t;
        #2;
        chk("b2b_allow", mem_allow, 1'b1);
        cyc();
        ex_valid = 1'b0;
        #2;
        chk("b2b_valid", wb_valid, 1'b1);
        chk("b2b_alu", wb_bus[63:32], 32'h55);
        cyc();

        // Reset while waiting for load data, then a stale response
        t = '0; t.rf_we = 1'b1; t.is_load = 1'b1; t.mem_en = 1'b1; t.waddr = 5'd9;
        t.alu = 32'h300; t.pc = 32'h50; t.b_en = 4'hF;
        ex_valid = 1'b1; ex_bus = t;
        cyc();
        ex_valid = 1'b0; dram_ack = 1'b1;
        cyc();
        dram_ack = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0; dram_rvalid = 1'b1; dram_rdata = 32'h12345678;
        #2;
        chk("rstw_req", dram_req, 1'b0);
        chk("rstw_valid", wb_valid, 1'b0);
        chk("rstw_allow", mem_allow, 1'b1);
        cyc();
        dram_rvalid = 1'b0;
        #2;
        chk("stale_valid", wb_valid, 1'b0);
        chk("stale_by", by_bus, '0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset       = (($urandom % 100) == 0);
            ex_valid    = (($urandom % 10) < 6);
            ex_bus      = rand_instr();
            wb_allow    = (($urandom % 10) < 7);
            dram_ack    = (m_full && m_need_ack) ? (($urandom % 2) == 1) : 1'b0;
            dram_rvalid = !dram_ack && (($urandom % 10) < 4);
            dram_rdata  = $urandom;
            cyc();
        end
        reset = 1'b0; ex_valid = 1'b0; dram_ack = 1'b0; dram_rvalid = 1'b0;
        cyc();
        @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
